// File: rtl/pll_lock_rst_gen.sv
// PLL lock qualifier: synchronizes pll_lock, waits for a stable lock run, then releases a registered reset.
// Optional lock-loss event counter enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_rst_gen #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_lock,
  output logic       rst_out_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [1:0] state_o,
  output logic [7:0] lock_loss_cnt
);

  localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STABLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     lock_s;
  logic                     lost_nxt;

  // Stage: lock synchronizer, the only consumer of pll_lock
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Stage: qualification FSM; RUN is entered on the edge that sees the
  // LOCK_STABLE_CYCLES-th consecutive high lock_s sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_nxt  = 1'b0;
    case (state)
      ST_WAIT: begin
        cnt_nxt = '0;
        if (lock_s) begin
          if (LOCK_STABLE_CYCLES == 1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_STABLE;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_WAIT;
          lost_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage: state and output registers (outputs come straight from flops)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_out_n <= (state_nxt == ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      lock_lost <= lost_nxt;
    end
  end

  assign state_o = state;

`ifdef PLL_LOCK_LOSS_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] loss_cnt_q;

  // Stage: lock-loss event counter, advances on the edge that raises lock_lost
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      loss_cnt_q <= 8'd0;
    end else if (lost_nxt) begin
      loss_cnt_q <= sat_inc8(loss_cnt_q);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Randomized self-checking bench for pll_lock_rst_gen against a run-length lock model.
module tb_pll_lock_rst_gen;
  localparam int S = 2;
  localparam int N = 16;
`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       rst_out_n;
  logic       ready;
  logic       lock_lost;
  logic [1:0] state_o;
  logic [7:0] lock_loss_cnt;

  pll_lock_rst_gen #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(N)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_lock(pll_lock),
    .rst_out_n(rst_out_n), .ready(ready), .lock_lost(lock_lost),
    .state_o(state_o), .lock_loss_cnt(lock_loss_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  // Model: pll_lock delay line, length of the current run of high lock samples, loss count
  bit m_q[S];
  int m_rc;
  int m_losses;
  bit m_lost;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_q[i] = 1'b0;
    m_rc = 0; m_losses = 0; m_lost = 1'b0;
  endtask

  task automatic model_edge(input bit lk);
    bit s_old;
    s_old = m_q[S-1];
    for (int i = S-1; i > 0; i--) m_q[i] = m_q[i-1];
    m_q[0] = lk;
    m_lost = (m_rc >= N) && !s_old;
    if (m_lost && m_losses < 255) m_losses++;
    m_rc = s_old ? ((m_rc >= N) ? N : m_rc + 1) : 0;
  endtask

  function automatic int exp_state();
    return (m_rc >= N) ? 2 : ((m_rc > 0) ? 1 : 0);
  endfunction

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("rst_out_n", 16'(rst_out_n), 16'(m_rc >= N));
      chk("ready", 16'(ready), 16'(m_rc >= N));
      chk("lock_lost", 16'(lock_lost), 16'(m_lost));
      chk("state_o", 16'(state_o), 16'(exp_state()));
      chk("lock_loss_cnt", 16'(lock_loss_cnt), CNT_EN ? 16'(m_losses) : 16'd0);
    end
  end

  task automatic cyc(input bit lk);
    #2 pll_lock = lk;
    @(posedge sys_clk);
    if (sys_rst_n) model_edge(lk);
  endtask

  // Asserts reset between edges and checks outputs cleared with no clock edge
  task automatic do_reset(input int hold);
    #3 sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out_n", 16'(rst_out_n), 16'd0);
    chk("async_ready", 16'(ready), 16'd0);
    chk("async_lock_lost", 16'(lock_lost), 16'd0);
    chk("async_state", 16'(state_o), 16'd0);
    chk("async_cnt", 16'(lock_loss_cnt), 16'd0);
    repeat (hold) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit saw_stable, saw_wait;
    pll_lock  = 1'b0;
    sys_rst_n = 1'b1;
    model_reset();
    #1 sys_rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge sys_clk);
    chk("reset_state", 16'(state_o), 16'd0);
    chk("reset_rst_out_n", 16'(rst_out_n), 16'd0);
    #3 sys_rst_n = 1'b1;

    // Reset already released with lock high from the first cycle: latency S+N
    n = 0; saw_stable = 1'b0;
    do begin
      cyc(1'b1); n++; #1;
      if (state_o == 2'd1) saw_stable = 1'b1;
    end while (!rst_out_n && n < 100);
    chk("lock_latency", 16'(n), 16'(S + N));
    chk("saw_stable", 16'(saw_stable), 16'd1);
    chk("ready_in_run", 16'(ready), 16'd1);

    // Lock drop in RUN: reset falls S+1 edges after the drop
    n = 0;
    do begin cyc(1'b0); n++; #1; end while (rst_out_n && n < 100);
    chk("loss_latency", 16'(n), 16'(S + 1));
    chk("loss_pulse", 16'(lock_lost), 16'd1);
    chk("loss_state", 16'(state_o), 16'd0);
    chk("loss_cnt", 16'(lock_loss_cnt), CNT_EN ? 16'd1 : 16'd0);
    cyc(1'b0); #1;
    chk("loss_pulse_end", 16'(lock_lost), 16'd0);

    // Reset then a one-cycle dropout at STABLE cycle 10: full recount
    do_reset(2);
    repeat (S + 10) cyc(1'b1);
    cyc(1'b0);
    n = 0; saw_wait = 1'b0;
    do begin
      cyc(1'b1); n++; #1;
      if (state_o == 2'd0) saw_wait = 1'b1;
    end while (!rst_out_n && n < 100);
    chk("dropout_latency", 16'(n), 16'(S + N));
    chk("dropout_saw_wait", 16'(saw_wait), 16'd1);

    // Loss followed immediately by lock return still recounts
    cyc(1'b0); cyc(1'b1);
    repeat (S + 2) cyc(1'b1);
    #1 chk("recount_not_run", 16'(rst_out_n), 16'd0);

    // Async reset mid-STABLE and mid-RUN
    repeat (N) cyc(1'b1);
    do_reset(1);
    repeat (S + 5) cyc(1'b1);
    do_reset(1);
    repeat (S + N + 3) cyc(1'b1);
    #1 chk("run_before_rst", 16'(rst_out_n), 16'd1);
    do_reset(3);

    // Randomized segments with occasional async resets
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      bit val;
      len = $urandom_range(1, 30);
      val = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
      else for (int k = 0; k < len; k++) cyc(($urandom_range(0, 19) == 0) ? !val : val);
    end

    // 260 lock-loss events
    for (int e = 0; e < 260; e++) begin
      repeat (S + N + 1) cyc(1'b1);
      repeat (S + 2) cyc(1'b0);
    end
    #1 chk("loss_saturate", 16'(lock_loss_cnt), CNT_EN ? 16'd255 : 16'd0);

    @(negedge sys_clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
